mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 256, number of DATA_W-bit memory words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, extra cycles per memory access; legal range 0..15.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 EX_MemRead  in  1  load request.
REQ-007 EX_MemWrite  in  1  store request.
REQ-008 EX_MemSize  in  2  access size: 00 byte, 01 half, 10 word(32), 11 dword (legal only when DATA_W=64).
REQ-009 EX_MemSigned  in  1  sign-extend load result when 1, zero-extend when 0.
REQ-010 EX_ALUOut  in  DATA_W  byte address, also passed through to WB.
REQ-011 EX_WrData  in  DATA_W  store data, right-aligned.
REQ-012 EX_RegWrite, EX_MemtoReg  in  1 each  control passed through to WB.
REQ-013 EX_RegDest  in  5  destination register passed through to WB.
REQ-014 MEM_Stall  out  1  combinational; high while the current access is not yet complete.
REQ-015 WB_MemReadOut, WB_ALUOut  out  DATA_W  registered load result and address.
REQ-016 WB_RegWrite, WB_MemtoReg  out  1 each; WB_RegDest  out  5  registered pass-through.
REQ-017 WB_MemErr  out  1  registered; access in the preceding commit was misaligned or illegal.

Function
REQ-018 req = EX_MemRead | EX_MemWrite; when both are high, the access SHALL be treated as illegal.
REQ-019 Internal counter wait_cnt (4 bits); MEM_Stall = req & (wait_cnt != WAIT_CYCLES).
REQ-020 FSM states: IDLE (wait_cnt=0) and WAIT (wait_cnt>0); IDLE->WAIT on req with WAIT_CYCLES>0; WAIT increments each stalled cycle; back to IDLE (wait_cnt=0) on the commit edge.
REQ-021 Commit edge: the rising edge where req is high and MEM_Stall is low; with WAIT_CYCLES=0, every req cycle commits, and MEM_Stall never asserts.
REQ-022 Upstream SHALL hold all EX_* inputs stable while MEM_Stall is high; the block does not latch them.
REQ-023 Word index = EX_ALUOut[log2(DATA_W/8) +: log2(DEPTH)]; upper address bits are ignored (wrap modulo DEPTH words).
REQ-024 Misaligned address: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0.
REQ-025 Store commit: write only the addressed byte lanes (byte-enable) from EX_WrData low bits; no write on misaligned/illegal access.
REQ-026 Load commit: select addressed lanes, extend per EX_MemSigned to DATA_W, register into WB_MemReadOut; misaligned/illegal load registers 0.
REQ-027 WB_MemErr SHALL be 1 for exactly the cycle after a commit of a misaligned/illegal access, else 0.
REQ-028 Each edge with MEM_Stall low: WB_* pass-through registers load the EX_* values; if no req, WB_MemReadOut holds its value.
REQ-029 Each edge with MEM_Stall high: WB_RegWrite and WB_MemErr SHALL load 0 (bubble); other WB_* registers hold their values.
REQ-030 Non-request cycles SHALL NOT change memory contents or the FSM state.

Reset
REQ-031 Reset asserted SHALL immediately clear all WB_* outputs to 0, wait_cnt to 0, FSM to IDLE, and every memory word to 0.
REQ-032 Reset during WAIT SHALL abandon the access: no memory write, no WB update; next access restarts from wait_cnt=0.

Structure
REQ-033 Shared package mem_pkg SHALL hold the MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and FSM state type.
REQ-034 Storage SHALL be one sub-module data_memory_bank (DATA_W, DEPTH; byte-enable write, async-reset clear); lane select/extend and FSM live in mem_stage.

Verification
REQ-035 W=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> WB_MemReadOut=0xDEADBEEF the cycle after the load; MEM_Stall never high.
REQ-036 LB signed @0x13 after the above -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LHU @0x12 -> 0x0000DEAD.
REQ-037 W=3: LW held -> MEM_Stall high exactly 3 cycles, WB_RegWrite=0 during those cycles, data valid in cycle 5.
REQ-038 LH @0x11 and SW @0x12 -> WB_MemErr=1 one cycle, memory unchanged, WB_MemReadOut=0 for the load.
REQ-039 W=3: reset pulse in 2nd stall cycle of SW 0x12345678 @0x20 -> outputs 0, later LW @0x20 returns 0.
REQ-040 DEPTH=256, DATA_W=32: SW 0xA5 @0x400 then LW @0x0 -> 0x000000A5 (wrap-around).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM state type
// and the size-to-byte-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 4'd1;
      SZ_HALF: return 4'd2;
      SZ_WORD: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bank.sv
// Word-organised data storage with per-byte write enables, combinational read
// and asynchronous clear of every word.
module data_memory_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array: cleared on reset, byte-lane write on enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: wait-state FSM, lane select/extend, alignment checks
// and the registered MEM/WB boundary.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic [1:0]        EX_MemSize,
  input  logic              EX_MemSigned,
  input  logic [DATA_W-1:0] EX_ALUOut,
  input  logic [DATA_W-1:0] EX_WrData,
  input  logic              EX_RegWrite,
  input  logic              EX_MemtoReg,
  input  logic [4:0]        EX_RegDest,
  output logic              MEM_Stall,
  output logic [DATA_W-1:0] WB_MemReadOut,
  output logic [DATA_W-1:0] WB_ALUOut,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [4:0]        WB_RegDest,
  output logic              WB_MemErr
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);

  mem_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              req_s, stall_s, commit_s, illegal_s, misal_s, err_s, we_s, sign_s;
  logic [3:0]        nbytes_s;
  logic [6:0]        nbits_s;
  logic [OFF_W-1:0]  off_s;
  logic [AW-1:0]     idx_s;
  logic [BYTES-1:0]  be_s;
  logic [DATA_W-1:0] wdata_s, rdata_s, shifted_s, lowmask_s, topbit_s, load_s;

  assign req_s    = EX_MemRead | EX_MemWrite;
  assign stall_s  = req_s & (wait_cnt_q != 4'(WAIT_CYCLES));
  assign commit_s = req_s & ~stall_s;
  assign MEM_Stall = stall_s;

  assign off_s     = EX_ALUOut[OFF_W-1:0];
  assign idx_s     = EX_ALUOut[OFF_W +: AW];
  assign nbytes_s  = size_bytes(EX_MemSize);
  assign nbits_s   = {nbytes_s, 3'b000};
  assign illegal_s = (EX_MemRead & EX_MemWrite) | ((EX_MemSize == SZ_DWORD) && (DATA_W == 32));
  assign misal_s   = (off_s & OFF_W'(nbytes_s - 4'd1)) != '0;
  assign err_s     = illegal_s | misal_s;

  // Store path: size mask and data moved up to the addressed lanes
  assign be_s    = BYTES'((16'd1 << nbytes_s) - 16'd1) << off_s;
  assign wdata_s = EX_WrData << {off_s, 3'b000};
  assign we_s    = commit_s & EX_MemWrite & ~err_s;

  data_memory_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we_s),
    .addr_i  (idx_s),
    .be_i    (be_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s)
  );

  // Load path: right-align, then mask to size; sign comes from the mask's top bit
  assign shifted_s = rdata_s >> {off_s, 3'b000};
  assign lowmask_s = {DATA_W{1'b1}} >> (8'(DATA_W) - {1'b0, nbits_s});
  assign topbit_s  = lowmask_s & ~(lowmask_s >> 1);
  assign sign_s    = |(shifted_s & topbit_s);
  assign load_s    = (shifted_s & lowmask_s) | ((EX_MemSigned & sign_s) ? ~lowmask_s : '0);

  // Wait-state FSM next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (stall_s) begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      ST_WAIT: begin
        if (stall_s) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else if (commit_s) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // MEM/WB boundary: bubble while stalled, otherwise pass through and capture loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_MemReadOut <= '0;
      WB_ALUOut     <= '0;
      WB_RegWrite   <= 1'b0;
      WB_MemtoReg   <= 1'b0;
      WB_RegDest    <= 5'd0;
      WB_MemErr     <= 1'b0;
    end else if (stall_s) begin
      WB_RegWrite <= 1'b0;
      WB_MemErr   <= 1'b0;
    end else begin
      WB_ALUOut   <= EX_ALUOut;
      WB_RegWrite <= EX_RegWrite;
      WB_MemtoReg <= EX_MemtoReg;
      WB_RegDest  <= EX_RegDest;
      WB_MemErr   <= commit_s & err_s;
      if (commit_s & EX_MemRead) begin
        WB_MemReadOut <= err_s ? '0 : load_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: two instances (no wait states and three wait
// states) checked against a byte-array reference model.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdv;
    logic        rw;
    logic        m2r;
    logic        err;
    logic [4:0]  dst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s  [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [1:0]  sz_s   [2];
  logic        sg_s   [2];
  logic [31:0] alu_s  [2];
  logic [31:0] wd_s   [2];
  logic        rw_s   [2];
  logic        m2r_s  [2];
  logic [4:0]  dst_s  [2];
  logic        stall_o [2];
  logic [31:0] wbrd_o  [2];
  logic [31:0] wbalu_o [2];
  logic        wbrw_o  [2];
  logic        wbm2r_o [2];
  logic [4:0]  wbdst_o [2];
  logic        wberr_o [2];

  logic [7:0]  mem_m   [2][1024];
  logic [31:0] last_rd [2];
  exp_t        sb_q    [2][$];
  logic        commit_seen [2];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_s[0]), .EX_MemRead(rd_s[0]), .EX_MemWrite(wr_s[0]),
    .EX_MemSize(sz_s[0]), .EX_MemSigned(sg_s[0]), .EX_ALUOut(alu_s[0]), .EX_WrData(wd_s[0]),
    .EX_RegWrite(rw_s[0]), .EX_MemtoReg(m2r_s[0]), .EX_RegDest(dst_s[0]), .MEM_Stall(stall_o[0]),
    .WB_MemReadOut(wbrd_o[0]), .WB_ALUOut(wbalu_o[0]), .WB_RegWrite(wbrw_o[0]),
    .WB_MemtoReg(wbm2r_o[0]), .WB_RegDest(wbdst_o[0]), .WB_MemErr(wberr_o[0]));

  mem_stage #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst_s[1]), .EX_MemRead(rd_s[1]), .EX_MemWrite(wr_s[1]),
    .EX_MemSize(sz_s[1]), .EX_MemSigned(sg_s[1]), .EX_ALUOut(alu_s[1]), .EX_WrData(wd_s[1]),
    .EX_RegWrite(rw_s[1]), .EX_MemtoReg(m2r_s[1]), .EX_RegDest(dst_s[1]), .MEM_Stall(stall_o[1]),
    .WB_MemReadOut(wbrd_o[1]), .WB_ALUOut(wbalu_o[1]), .WB_RegWrite(wbrw_o[1]),
    .WB_MemtoReg(wbm2r_o[1]), .WB_RegDest(wbdst_o[1]), .WB_MemErr(wberr_o[1]));

  function automatic int wcyc(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 1024; i++) mem_m[k][i] = 8'h00;
    last_rd[k] = 32'h0;
  endtask

  task automatic drive_idle(input int k);
    rd_s[k] = 1'b0; wr_s[k] = 1'b0; sz_s[k] = 2'b00; sg_s[k] = 1'b0;
    alu_s[k] = 32'h0; wd_s[k] = 32'h0; rw_s[k] = 1'b0; m2r_s[k] = 1'b0; dst_s[k] = 5'd0;
  endtask

  task automatic check_wb_zero(input int k, input string nm);
    chk({nm, "_rd"},  wbrd_o[k], 32'h0);
    chk({nm, "_alu"}, wbalu_o[k], 32'h0);
    chk({nm, "_ctl"}, {24'h0, wbrw_o[k], wbm2r_o[k], wberr_o[k], wbdst_o[k]}, 32'h0);
  endtask

  // Issue one access (called #1 after a rising edge), wait out the stall, push the model result
  task automatic do_acc(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int   stalls = 0;
    bit   done = 0;
    int   nb;
    bit   err;
    exp_t e;
    logic [31:0] v;
    rd_s[k] = rd; wr_s[k] = wr; sz_s[k] = sz; sg_s[k] = sg; alu_s[k] = a; wd_s[k] = wd;
    rw_s[k] = 1'($urandom_range(0, 1)); m2r_s[k] = 1'($urandom_range(0, 1));
    dst_s[k] = 5'($urandom_range(0, 31));
    while (!done && stalls < 20) begin
      @(negedge clk);
      if (stall_o[k]) begin
        stalls++;
        if (stalls > 1) chk("stall_bubble_rw", {31'h0, wbrw_o[k]}, 32'h0);
        @(posedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL stall_timeout: inst %0d still stalled after %0d cycles", k, stalls);
    end
    chk("stall_cycles", 32'(stalls), 32'(wcyc(k)));
    nb  = 1 << sz;
    err = (rd && wr) || (sz == 2'b11) || ((a % nb) != 0);
    if (wr && !err) begin
      for (int i = 0; i < nb; i++) mem_m[k][(a + i) % 1024] = 8'(wd >> (8 * i));
    end
    if (rd) begin
      v = 32'h0;
      if (!err) begin
        for (int i = 0; i < nb; i++) v = v | (32'(mem_m[k][(a + i) % 1024]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      end
      last_rd[k] = v;
    end
    e.alu = a; e.rdv = last_rd[k]; e.rw = rw_s[k]; e.m2r = m2r_s[k]; e.err = err; e.dst = dst_s[k];
    sb_q[k].push_back(e);
    @(posedge clk);
    #1;
    drive_idle(k);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Commit detector: an edge where a request is presented and not stalled
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      commit_seen[k] <= !rst_s[k] && (rd_s[k] || wr_s[k]) && !stall_o[k];
  end

  // Monitor: pop and compare after each commit, otherwise the error flag must be low
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (commit_seen[k]) begin
        if (sb_q[k].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_empty: inst %0d committed with no expected entry", k);
        end else begin
          e = sb_q[k].pop_front();
          chk("wb_rdata", wbrd_o[k], e.rdv);
          chk("wb_alu", wbalu_o[k], e.alu);
          chk("wb_ctl", {24'h0, wbrw_o[k], wbm2r_o[k], wberr_o[k], wbdst_o[k]},
              {24'h0, e.rw, e.m2r, e.err, e.dst});
        end
      end else if (!rst_s[k]) begin
        chk("err_idle", {31'h0, wberr_o[k]}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          op;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; drive_idle(k); model_clear(k); commit_seen[k] = 1'b0;
    end
    #3;
    check_wb_zero(0, "reset0");
    check_wb_zero(1, "reset3");
    @(negedge clk);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    idle_cycles(1);

    // Directed, no wait states
    do_acc(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_acc(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_0x10", wbrd_o[0], 32'hDEADBEEF);
    do_acc(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lb_0x13", wbrd_o[0], 32'hFFFFFFDE);
    do_acc(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lbu_0x13", wbrd_o[0], 32'h000000DE);
    do_acc(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lhu_0x12", wbrd_o[0], 32'h0000DEAD);
    do_acc(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    chk("lh_mis_rd", wbrd_o[0], 32'h0);
    chk("lh_mis_err", {31'h0, wberr_o[0]}, 32'h1);
    do_acc(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111);
    chk("sw_mis_err", {31'h0, wberr_o[0]}, 32'h1);
    do_acc(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("mem_unchanged", wbrd_o[0], 32'hDEADBEEF);
    do_acc(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("rdwr_illegal_err", {31'h0, wberr_o[0]}, 32'h1);
    do_acc(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h000000A5);
    do_acc(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("wrap_lw_0x0", wbrd_o[0], 32'h000000A5);

    // Directed, three wait states
    do_acc(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
    do_acc(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("w3_lw_0x10", wbrd_o[1], 32'hCAFEF00D);

    // Reset in the second stall cycle of a store abandons it
    rd_s[1] = 1'b0; wr_s[1] = 1'b1; sz_s[1] = 2'b10; alu_s[1] = 32'h20; wd_s[1] = 32'h12345678;
    rw_s[1] = 1'b1; dst_s[1] = 5'd7;
    @(posedge clk);
    #1;
    chk("rst_wait_stall", {31'h0, stall_o[1]}, 32'h1);
    rst_s[1] = 1'b1;
    #1;
    check_wb_zero(1, "rst_wait");
    drive_idle(1);
    model_clear(1);
    @(negedge clk);
    rst_s[1] = 1'b0;
    idle_cycles(1);
    do_acc(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rst_abandon_lw", wbrd_o[1], 32'h0);

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 80; n++) begin
        op = $urandom_range(0, 9);
        sz = 2'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 1)) << 10);
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        do_acc(k, op <= 4 || op == 9, op >= 5, sz, 1'($urandom_range(0, 1)), a, $urandom);
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end
    end

    idle_cycles(3);
    for (int k = 0; k < 2; k++) chk("sb_drained", 32'(sb_q[k].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
